// File: rtl/uart_mike_rx.sv
// UART receive front end: 2-flop input synchroniser, start-bit qualification, mid-bit sampling.
// Optional even-parity bit between data and stop when UART_MIKE_RX_PARITY_EN is defined.
module uart_mike_rx #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT    = 868
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rxd,
  input  logic                       rx_flag_clr,
  output logic                       rx_start,
  output logic                       rx_done,
  output logic [UART_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_flag,
  output logic                       rx_frame_err,
  output logic                       rx_overrun,
  output logic                       rx_parity_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int BCNT_W   = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W   = $clog2(UART_DATA_WIDTH);

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BCNT_W-1:0] BCNT_HALF = BCNT_W'(HALF_BIT - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(UART_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_MIKE_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                     state, state_next;
  logic                       rx_meta, rxs;
  logic [BCNT_W-1:0]          bcnt;
  logic [BIDX_W-1:0]          bidx;
  logic [UART_DATA_WIDTH-1:0] sreg;
  logic                       bit_end;
  logic                       start_nxt, done_nxt, shift_en;

  assign bit_end = (bcnt == BCNT_LAST);

  always_comb begin
    state_next = state;
    start_nxt  = 1'b0;
    done_nxt   = 1'b0;
    shift_en   = 1'b0;
    case (state)
      S_IDLE:  if (!rxs) state_next = S_START;
      S_START: begin
        if (bcnt == BCNT_HALF) begin
          if (!rxs) begin
            state_next = S_DATA;
            start_nxt  = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
`ifdef UART_MIKE_RX_PARITY_EN
          if (bidx == BIDX_LAST) state_next = S_PARITY;
`else
          if (bidx == BIDX_LAST) state_next = S_STOP;
`endif
        end
      end
`ifdef UART_MIKE_RX_PARITY_EN
      S_PARITY: if (bit_end) state_next = S_STOP;
`endif
      S_STOP: begin
        if (bit_end) begin
          done_nxt   = 1'b1;
          state_next = rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: if (rxs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state   <= S_IDLE;
      bcnt    <= '0;
      bidx    <= '0;
      sreg    <= '0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      state   <= state_next;
      // bcnt restarts on every state change and wraps each bit period while in DATA
      if (state == S_IDLE || state_next != state || bit_end) bcnt <= '0;
      else                                                  bcnt <= bcnt + 1'b1;
      if (start_nxt)     bidx <= '0;
      else if (shift_en) bidx <= bidx + 1'b1;
      if (shift_en) sreg <= {rxs, sreg[UART_DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_start     <= 1'b0;
      rx_done      <= 1'b0;
      rx_data      <= '0;
      rx_flag      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_start <= start_nxt;
      rx_done  <= done_nxt;
      // a completing frame takes priority over an acknowledge in the same cycle
      if (done_nxt) begin
        rx_frame_err <= ~rxs;
        if (rx_flag_clr || !rx_flag) begin
          rx_data    <= sreg;
          rx_flag    <= 1'b1;
          rx_overrun <= 1'b0;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_flag_clr) begin
        rx_flag    <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

`ifdef UART_MIKE_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      if (state == S_PARITY && bit_end) par_bit <= rxs;
      if (done_nxt) rx_parity_err <= (^sreg) ^ par_bit;
    end
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mike_rx.sv
// Randomised + directed bench for uart_mike_rx against a frame-level reference model.
module tb_uart_mike_rx;

  localparam int W = 8;
  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_MIKE_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int START_LAT = 3 + H;
  localparam int DONE_LAT  = START_LAT + (W + PB + 1) * C;

  logic         clk, rst, rxd, rx_flag_clr;
  logic         rx_start, rx_done, rx_flag, rx_frame_err, rx_overrun, rx_parity_err;
  logic [W-1:0] rx_data;

  uart_mike_rx #(.UART_DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .rx_flag_clr   (rx_flag_clr),
    .rx_start      (rx_start),
    .rx_done       (rx_done),
    .rx_data       (rx_data),
    .rx_flag       (rx_flag),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_start = 0, n_done = 0, start_lat = -1, done_lat = -1, fall_cyc = 0;
  always @(negedge clk) begin
    if (rx_start) begin n_start++; start_lat = cyc - fall_cyc; end
    if (rx_done)  begin n_done++;  done_lat  = cyc - fall_cyc; end
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the receiver should be reporting after each event
  logic [W-1:0] exp_data = '0;
  logic         exp_flag = 0, exp_ovr = 0, exp_ferr = 0, exp_perr = 0;

  function automatic void model_complete(input logic [W-1:0] d, input logic stop,
                                         input logic pbit, input logic clr);
    if (clr || !exp_flag) begin
      exp_data = d;
      exp_flag = 1'b1;
      exp_ovr  = 1'b0;
    end else begin
      exp_ovr = 1'b1;
    end
    exp_ferr = ~stop;
    exp_perr = (PB == 1) ? ((^d) ^ pbit) : 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".data"}, 32'(rx_data), 32'(exp_data));
    check({tag, ".flag"}, 32'(rx_flag), 32'(exp_flag));
    check({tag, ".ovr"},  32'(rx_overrun), 32'(exp_ovr));
    check({tag, ".ferr"}, 32'(rx_frame_err), 32'(exp_ferr));
    check({tag, ".perr"}, 32'(rx_parity_err), 32'(exp_perr));
  endtask

  // Must be called at a negedge; rxd falls immediately.
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic pbit,
                            input int extra_low);
    fall_cyc = cyc;
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      rxd = d[i];
      repeat (C) @(negedge clk);
    end
    if (PB == 1) begin
      rxd = pbit;
      repeat (C) @(negedge clk);
    end
    rxd = stop;
    repeat (C) @(negedge clk);
    if (!stop) repeat (extra_low) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr(input string tag);
    @(negedge clk) rx_flag_clr = 1'b1;
    @(negedge clk) rx_flag_clr = 1'b0;
    exp_flag = 1'b0;
    exp_ovr  = 1'b0;
    check({tag, ".clr.flag"}, 32'(rx_flag), 32'(exp_flag));
    check({tag, ".clr.ovr"},  32'(rx_overrun), 32'(exp_ovr));
  endtask

  // mode 0: no ack; 1: ack coincides with completion; 2: ack after the frame
  task automatic frame(input string tag, input logic [W-1:0] d, input logic stop,
                       input logic pbit, input int extra_low, input int mode);
    int s0, d0;
    s0 = n_start;
    d0 = n_done;
    @(negedge clk);
    fork
      send_frame(d, stop, pbit, extra_low);
      if (mode == 1) begin
        repeat (DONE_LAT - 1) @(posedge clk);
        @(negedge clk) rx_flag_clr = 1'b1;
        @(negedge clk) rx_flag_clr = 1'b0;
      end
    join
    model_complete(d, stop, pbit, mode == 1);
    check({tag, ".nstart"}, 32'(n_start - s0), 32'd1);
    check({tag, ".ndone"},  32'(n_done - d0), 32'd1);
    check({tag, ".slat"},   32'(start_lat), 32'(START_LAT));
    check({tag, ".dlat"},   32'(done_lat), 32'(DONE_LAT));
    check_outputs(tag);
    if (mode == 2) pulse_clr(tag);
  endtask

  initial begin
    int s0, d0;
    logic [W-1:0] rd;
    rst = 1'b1; rxd = 1'b1; rx_flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.start", 32'(rx_start), 32'd0);
    check("rst.done",  32'(rx_done), 32'd0);
    check_outputs("rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    frame("t1", 8'hA5, 1'b1, ^8'hA5, 0, 0);

    s0 = n_start; d0 = n_done;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("t2.nstart", 32'(n_start - s0), 32'd0);
    check("t2.ndone",  32'(n_done - d0), 32'd0);
    check_outputs("t2");
    pulse_clr("t2");

    frame("t3", 8'h3C, 1'b0, ^8'h3C, 40, 0);
    pulse_clr("t3");

    frame("t4a", 8'h11, 1'b1, ^8'h11, 0, 0);
    frame("t4b", 8'h22, 1'b1, ^8'h22, 0, 0);
    pulse_clr("t4");
    frame("t4c", 8'h33, 1'b1, ^8'h33, 0, 2);

    frame("t5a", 8'h11, 1'b1, ^8'h11, 0, 0);
    frame("t5b", 8'h22, 1'b1, ^8'h22, 0, 1);

    s0 = n_done;
    @(negedge clk);
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * C + H) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_data = '0; exp_flag = 0; exp_ovr = 0; exp_ferr = 0; exp_perr = 0;
    check("t6.start", 32'(rx_start), 32'd0);
    check("t6.done",  32'(rx_done), 32'd0);
    check_outputs("t6.rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (C * (W + 3)) @(negedge clk);
    check("t6.ndone", 32'(n_done - s0), 32'd0);
    frame("t6p1", 8'h5A, 1'b1, 1'b1, 0, 2);
    frame("t6p0", 8'h5A, 1'b1, 1'b0, 0, 2);

    for (int k = 0; k < 10; k++) begin
      rd = W'($urandom);
      frame($sformatf("rnd%0d", k), rd, $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 30), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mike_rx.md
Name: uart_mike_rx

Overview:
- Serial receive front end that feeds the UART controller FSM.
- Synchronises the asynchronous serial input, detects and qualifies the start bit, and samples data bits at mid-bit. Stop bit and optional parity are also sampled mid-bit.
- Presents the received word with `rx_start`/`rx_done` pulses and a sticky data-valid flag. The controller acknowledges the flag via `rx_flag_clr`.

Parameters:
- `UART_DATA_WIDTH`, 8, number of data bits per frame (LSB first). Legal range 5..9.
- `CLKS_PER_BIT`, 868, clk cycles per bit period (100 MHz / 115200). Minimum 4.
- `HALF_BIT`, `CLKS_PER_BIT/2`, derived (localparam), mid-bit sample offset.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rxd` in 1: serial line, idle high, asynchronous to clk.
- `rx_flag_clr` in 1: single-cycle acknowledge from controller; clears `rx_flag` and `rx_overrun`.
- `rx_start` out 1: one-cycle pulse when a start bit is qualified.
- `rx_done` out 1: one-cycle pulse when the stop bit has been sampled.
- `rx_data` out `UART_DATA_WIDTH`: last received word, held until the next completed frame.
- `rx_flag` out 1: sticky "new data" flag.
- `rx_frame_err` out 1: status of the last frame; 1 if its stop bit was sampled 0.
- `rx_overrun` out 1: sticky; a frame completed while `rx_flag` was already 1.
- `rx_parity_err` out 1: parity status of the last frame (see Optional Feature).

Behaviour:
- Reset (async, `rst`=1):
  - State = IDLE; counters = 0; synchroniser flops = 1.
  - `rx_start`, `rx_done`, `rx_flag`, `rx_frame_err`, `rx_overrun`, `rx_parity_err` = 0; `rx_data` = 0.
  - Reset mid-frame abandons the frame with no pulses.
- Input path: `rxd` passes through a 2-flop synchroniser. `rxs` is the synchronised value (2-cycle latency). All decisions use `rxs`.
- Counters:
  - Baud counter `bcnt` counts 0..`CLKS_PER_BIT`-1 and is cleared on every state entry.
  - Bit index `bidx` counts 0..`UART_DATA_WIDTH`-1.
- State IDLE: `rxs`==0 -> START, `bcnt`=0.
- State START: when `bcnt`==`HALF_BIT`-1, sample `rxs`:
  - 0 -> pulse `rx_start` next cycle, go to DATA, `bidx`=0.
  - 1 -> false start: go to IDLE, no pulse.
  - DATA samples then fall on mid-bit.
- State DATA: when `bcnt`==`CLKS_PER_BIT`-1, shift `rxs` into the MSB of the shift register (shift right), increment `bidx`. After bit `UART_DATA_WIDTH`-1 -> STOP (or PARITY with feature).
- State STOP: when `bcnt`==`CLKS_PER_BIT`-1, sample `rxs`:
  - Always: `rx_data`<=shift register (unless overrun, below), pulse `rx_done`, `rx_frame_err`<=~`rxs`.
  - `rxs`==1 -> IDLE.
  - `rxs`==0 -> BREAK.
- State BREAK: wait for `rxs`==1, then go to IDLE. This prevents a held-low line from retriggering.
- `rx_flag`/`rx_overrun`:
  - On completion with `rx_flag`==0: `rx_flag`<=1, `rx_data` updated.
  - On completion with `rx_flag`==1 (and no clear in the same cycle): `rx_overrun`<=1; `rx_data` is NOT overwritten; `rx_frame_err` and `rx_parity_err` still update.
  - `rx_flag_clr` clears both `rx_flag` and `rx_overrun`.
  - Simultaneous completion and `rx_flag_clr`: completion wins. `rx_flag` stays 1, `rx_data` updates, `rx_overrun` is cleared (not set).
- `rx_flag_clr` while `rx_flag`==0: no effect.
- Pulse outputs are registered, exactly one cycle wide, and mutually exclusive within a frame.

Optional Feature:
- Macro `UART_MIKE_RX_PARITY_EN`.
- Defined:
  - PARITY state is inserted between DATA and STOP. It samples one even-parity bit at `bcnt`==`CLKS_PER_BIT`-1.
  - `rx_parity_err` is set to (XOR of data bits) XOR (parity bit), loaded alongside `rx_data`/`rx_frame_err` on completion.
  - Frame length becomes `UART_DATA_WIDTH`+3 bits.
- Undefined: no PARITY state; `rx_parity_err` is tied to 0; frame is `UART_DATA_WIDTH`+2 bits.

Test Plan (`CLKS_PER_BIT`=16, `UART_DATA_WIDTH`=8):
1. Frame 0xA5 with valid stop -> `rx_start` pulses once ~11 cycles after the falling edge; `rx_done` pulses once ~155 cycles after the edge; `rx_data`=0xA5; `rx_flag`=1; `rx_frame_err`=0; `rx_overrun`=0.
2. Low glitch of 4 cycles on `rxd` -> no `rx_start`, no `rx_done`; state returns to IDLE; outputs unchanged.
3. Frame 0x3C with stop bit 0, line held low 40 cycles, then high -> `rx_done` pulses; `rx_frame_err`=1; no second `rx_start` until the line is high and a new falling edge arrives.
4. Two frames 0x11 then 0x22, no `rx_flag_clr` between them -> `rx_data`=0x11, `rx_overrun`=1. Then `rx_flag_clr` -> `rx_flag`=0, `rx_overrun`=0. A third frame 0x33 -> `rx_data`=0x33.
5. `rx_flag_clr` asserted in the same cycle as the second frame's completion -> `rx_flag`=1, `rx_data`=0x22, `rx_overrun`=0.
6. `rst` pulsed at data bit 4 of frame 0xFF -> all outputs 0 immediately. Next clean frame 0x5A is received correctly. With `UART_MIKE_RX_PARITY_EN` defined: 0x5A sent with parity bit 1 -> `rx_parity_err`=1; with parity bit 0 -> `rx_parity_err`=0.
